// File: rtl/nn_pkg.sv
// Shared constants and helpers for the neuron-layer datapath blocks.
package nn_pkg;

   localparam int NN_DATA_W = 8;
   localparam int NN_FRAC_W = 4;
   localparam int NN_ACC_W  = 20;
   localparam int NN_ADDR_W = 8;

   // Clamp a sign-extended value into the signed range of 'width' bits.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int unsigned width);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 32'd1));
      if (value > max_v) begin
         sat_signed = max_v;
      end else if (value < min_v) begin
         sat_signed = min_v;
      end else begin
         sat_signed = value;
      end
   endfunction

endpackage

// File: rtl/nn_activation_quant.sv
// Converts an accumulator value to the data format: arithmetic shift, optional
// ReLU, then saturation to DATA_W bits.
module nn_activation_quant
   import nn_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W,
   parameter int FRAC_W = NN_FRAC_W,
   parameter int ACC_W  = NN_ACC_W
) (
   input  logic signed [ACC_W-1:0]  i_acc,
   input  logic                     i_relu_en,
   output logic signed [DATA_W-1:0] o_q
);

   logic signed [ACC_W-1:0] w_shift;
   logic signed [ACC_W-1:0] w_relu;
   logic signed [63:0]      w_relu_ext;
   logic signed [63:0]      w_q_ext;
   logic [63-DATA_W:0]      w_q_unused_hi;

   always_comb begin
      w_shift = i_acc >>> FRAC_W;
      if (i_relu_en && w_shift[ACC_W-1]) begin
         w_relu = {ACC_W{1'b0}};
      end else begin
         w_relu = w_shift;
      end
   end

   assign w_relu_ext = {{(64-ACC_W){w_relu[ACC_W-1]}}, w_relu};
   assign w_q_ext    = sat_signed(w_relu_ext, DATA_W);
   // The saturated value fits DATA_W bits, so the upper part is pure sign.
   assign {w_q_unused_hi, o_q} = w_q_ext;

endmodule

// File: rtl/neuron_mac_unit.sv
// Streaming signed MAC for one layer: register, multiply, accumulate, then
// quantize and write one result per neuron.
module neuron_mac_unit
   import nn_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W,
   parameter int FRAC_W = NN_FRAC_W,
   parameter int ACC_W  = NN_ACC_W,
   parameter int ADDR_W = NN_ADDR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic                     in_last,
   input  logic                     in_layer_done,
   input  logic [ADDR_W-1:0]        in_wr_addr,
   input  logic signed [DATA_W-1:0] weight_data,
   input  logic signed [DATA_W-1:0] neuro_data,
   input  logic                     relu_en,
   output logic                     out_we,
   output logic [ADDR_W-1:0]        out_addr,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     layer_done,
   output logic                     busy,
   output logic                     acc_ovf
);

   logic                     r_s1_valid, r_s1_last, r_s1_ld, r_s1_relu;
   logic [ADDR_W-1:0]        r_s1_addr;
   logic [DATA_W-1:0]        r_s1_w, r_s1_n;
   logic                     r_s2_valid, r_s2_last, r_s2_ld, r_s2_relu;
   logic [ADDR_W-1:0]        r_s2_addr;
   logic [2*DATA_W-1:0]      r_s2_p;
   logic                     r_s3_valid, r_s3_last, r_s3_ld, r_s3_relu;
   logic [ADDR_W-1:0]        r_s3_addr;
   logic signed [ACC_W-1:0]  r_acc;
   logic                     r_first;
   logic                     r_out_we, r_layer_done, r_acc_ovf;
   logic [ADDR_W-1:0]        r_out_addr;
   logic signed [DATA_W-1:0] r_out_data;

   logic [2*DATA_W-1:0]      w_a_ext, w_b_ext;
   logic signed [ACC_W:0]    w_base, w_p_ext, w_sum;
   logic signed [63:0]       w_sum_ext, w_sat_ext;
   logic                     w_clamped;
   logic signed [DATA_W-1:0] w_q;

   assign w_a_ext = {{DATA_W{r_s1_w[DATA_W-1]}}, r_s1_w};
   assign w_b_ext = {{DATA_W{r_s1_n[DATA_W-1]}}, r_s1_n};

   // Control tags are qualified here so later stages never see stray last/layer_done.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_ld    <= 1'b0;
         r_s1_relu  <= 1'b0;
         r_s1_addr  <= {ADDR_W{1'b0}};
         r_s1_w     <= {DATA_W{1'b0}};
         r_s1_n     <= {DATA_W{1'b0}};
         r_s2_valid <= 1'b0;
         r_s2_last  <= 1'b0;
         r_s2_ld    <= 1'b0;
         r_s2_relu  <= 1'b0;
         r_s2_addr  <= {ADDR_W{1'b0}};
         r_s2_p     <= {(2*DATA_W){1'b0}};
      end else begin
         r_s1_valid <= in_valid;
         r_s1_last  <= in_valid & in_last;
         r_s1_ld    <= in_valid & in_last & in_layer_done;
         r_s1_relu  <= relu_en;
         r_s1_addr  <= in_wr_addr;
         r_s1_w     <= weight_data;
         r_s1_n     <= neuro_data;
         r_s2_valid <= r_s1_valid;
         r_s2_last  <= r_s1_last;
         r_s2_ld    <= r_s1_ld;
         r_s2_relu  <= r_s1_relu;
         r_s2_addr  <= r_s1_addr;
         r_s2_p     <= w_a_ext * w_b_ext;
      end
   end

   assign w_base    = r_first ? {(ACC_W+1){1'b0}} : {r_acc[ACC_W-1], r_acc};
   assign w_p_ext   = {{(ACC_W+1-2*DATA_W){r_s2_p[2*DATA_W-1]}}, r_s2_p};
   assign w_sum     = w_base + w_p_ext;
   assign w_sum_ext = {{(63-ACC_W){w_sum[ACC_W]}}, w_sum};
   assign w_sat_ext = sat_signed(w_sum_ext, ACC_W);
   assign w_clamped = (w_sat_ext != w_sum_ext);

   // Accumulate stage; bubbles leave acc and first untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s3_valid <= 1'b0;
         r_s3_last  <= 1'b0;
         r_s3_ld    <= 1'b0;
         r_s3_relu  <= 1'b0;
         r_s3_addr  <= {ADDR_W{1'b0}};
         r_acc      <= {ACC_W{1'b0}};
         r_first    <= 1'b1;
         r_acc_ovf  <= 1'b0;
      end else begin
         r_s3_valid <= r_s2_valid;
         r_s3_last  <= r_s2_last;
         r_s3_ld    <= r_s2_ld;
         r_s3_relu  <= r_s2_relu;
         r_s3_addr  <= r_s2_addr;
         if (r_s2_valid) begin
            r_acc     <= w_sat_ext[ACC_W-1:0];
            r_first   <= r_s2_last;
            r_acc_ovf <= r_acc_ovf | w_clamped;
         end
      end
   end

   nn_activation_quant #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_quant (
      .i_acc     (r_acc),
      .i_relu_en (r_s3_relu),
      .o_q       (w_q)
   );

   // Output register: one write strobe per completed neuron.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_we     <= 1'b0;
         r_layer_done <= 1'b0;
         r_out_addr   <= {ADDR_W{1'b0}};
         r_out_data   <= {DATA_W{1'b0}};
      end else begin
         r_out_we     <= r_s3_valid & r_s3_last;
         r_layer_done <= r_s3_valid & r_s3_last & r_s3_ld;
         if (r_s3_valid && r_s3_last) begin
            r_out_addr <= r_s3_addr;
            r_out_data <= w_q;
         end
      end
   end

   assign out_we     = r_out_we;
   assign out_addr   = r_out_addr;
   assign out_data   = r_out_data;
   assign layer_done = r_layer_done;
   assign acc_ovf    = r_acc_ovf;
   assign busy       = r_s1_valid | r_s2_valid | r_s3_valid | ~r_first;

endmodule

// File: doc/neuron_mac_unit.md
Name: neuron_mac_unit

Overview:
- Datapath consumer of the layer address-sequencing stream.
- Per beat, takes one weight word and one neuron-activation word returned from memory and forms a signed fixed-point multiply-accumulate (MAC).
- On the last beat of a neuron, applies optional ReLU, quantizes and saturates the sum, and issues one write of the result to the neuron memory at the tagged write address.
- Pulses layer_done when the final neuron of a layer has been written.

Parameters:
- DATA_W, 8: signed weight/activation/result width, two's complement.
- FRAC_W, 4: fractional bits of the data format (Q(DATA_W-FRAC_W).FRAC_W).
- ACC_W, 20: signed accumulator width; must be >= 2*DATA_W.
- ADDR_W, 8: neuron write address width.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- in_valid, in, 1: beat valid; weight_data/neuro_data/tags meaningful.
- in_last, in, 1: last beat of the current neuron (qualified by in_valid).
- in_layer_done, in, 1: last neuron of the layer (qualified by in_valid & in_last).
- in_wr_addr, in, ADDR_W: write address tag for the current neuron.
- weight_data, in, DATA_W: signed weight.
- neuro_data, in, DATA_W: signed previous-layer activation.
- relu_en, in, 1: apply ReLU at output; sampled with the last beat.
- out_we, out, 1: one-cycle write strobe.
- out_addr, out, ADDR_W: write address.
- out_data, out, DATA_W: quantized result.
- layer_done, out, 1: one-cycle pulse coincident with the final out_we of a layer.
- busy, out, 1: any pipeline stage valid or partial sum pending.
- acc_ovf, out, 1: sticky accumulator saturation flag.

Behaviour:
- Reset: out_we=0, out_addr=0, out_data=0, layer_done=0, busy=0, acc_ovf=0. All stage valids cleared, acc=0, first=1. Reset mid-neuron discards the partial sum; the next beat starts a fresh neuron.
- Pipeline stage S1 (edge 1): register operands, valid, last, layer_done, addr, relu_en.
- Pipeline stage S2 (edge 2): p = signed(a)*signed(b), 2*DATA_W bits, registered with tags.
- Pipeline stage S3 (edge 3):
  - If valid: sum = (first ? 0 : acc) + sext(p), computed at ACC_W+1 bits.
  - If sum exceeds the ACC_W signed range, clamp to max/min and set acc_ovf.
  - Register acc=sum, first=last.
- Latency: beat with in_last sampled at edge t gives out_we=1 after edge t+3, for exactly one cycle. out_addr and out_data are valid in the same cycle.
- Output quantization:
  - q = sum >>> FRAC_W (arithmetic shift).
  - If relu_en and q<0, then q=0.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Bubbles: in_valid=0 inserts a bubble; acc and first hold; no output.
- Control qualification: in_last/in_layer_done without in_valid are ignored. in_layer_done without in_last is ignored.
- Single-beat neuron (first and last on the same beat): result = quant(p).
- Back-to-back neurons need no gap. The beat after a last beat starts from 0, and the full throughput is 1 beat/cycle.
- layer_done is asserted with out_we for the beat carrying in_layer_done; otherwise 0.
- busy = S1.valid | S2.valid | S3.valid | !first.
- acc_ovf is cleared only by reset.
- No backpressure: the consumer must accept out_we every cycle it is asserted.

Decomposition:
- Package nn_pkg holds the default DATA_W/FRAC_W/ACC_W/ADDR_W constants and a signed-saturate function (value, width).
- Sub-module nn_activation_quant: combinational shift, ReLU and saturate from ACC_W to DATA_W; reusable by other layer blocks.

Test Plan:
- Dot product: weights 16,16,16 with neuro 16,32,-16, addr 0x40, last on beat 3 -> single out_we 3 cycles after beat 3, out_addr=0x40, out_data=32 (2.0).
- ReLU: single beat, w=16, n=-32 -> relu_en=0 gives out_data=0xE0 (-2.0); relu_en=1 gives out_data=0.
- Saturation, default widths: 4 beats of 127*127 -> out_data=127, acc_ovf=0. With ACC_W=16: 3 beats of 127*127 -> acc clamps at 32767, acc_ovf=1 and stays 1 until reset.
- Bubbles: the scenario-1 beats with 2 idle cycles between each -> identical out_data=32, exactly one out_we, busy high from beat 1 until out_we.
- Reset mid-neuron: 2 beats (16*16, 16*16), reset, then single beat w=16, n=16, last, addr 0x05 -> out_data=16 at 0x05, no stale contribution.
- Back-to-back neurons with layer end:
  - Neuron A: 1 beat, 16*32, addr 0x10.
  - Neuron B: 1 beat, 16*16, addr 0x11, with in_layer_done, on consecutive cycles.
  - Expected: out 32 @0x10, then 16 @0x11 on consecutive cycles; layer_done high only with the 0x11 write.
